// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: opcodes, A-channel FSM encoding, legality check.
package tl_ul_pkg;

  // A-channel opcodes accepted by an uncached-lightweight master
  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_GET         = 3'd4;

  // D-channel opcodes expected in reply
  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic {
    A_IDLE = 1'b0,
    A_SEND = 1'b1
  } a_state_e;

  function automatic logic is_ul_legal(input logic [2:0] opcode);
    return (opcode == A_GET) || (opcode == A_PUT_FULL) || (opcode == A_PUT_PARTIAL);
  endfunction

endpackage

// File: rtl/tl_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible whenever empty is low.
// Pointers carry one extra wrap bit so full and empty are distinguished.
module tl_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr_reg[AW-1:0]];

  // Storage array written on accepted pushes; no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointers, wrapping naturally through the extra bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/tilelink_ul_master_mo.sv
// TileLink-UL master with several requests in flight: commands are queued,
// given the lowest free source ID, issued on A, and D replies are matched
// back by d_source and returned through a one-entry response register.
module tilelink_ul_master_mo
  import tl_ul_pkg::*;
#(
  parameter int TL_ADDR_WIDTH   = 64,
  parameter int TL_DATA_WIDTH   = 64,
  parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
  parameter int TL_SOURCE_WIDTH = 3,
  parameter int TL_SINK_WIDTH   = 3,
  parameter int TL_SIZE_WIDTH   = 8,
  parameter int CMD_FIFO_DEPTH  = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_opcode,
  input  logic [2:0]                 cmd_param,
  input  logic [TL_ADDR_WIDTH-1:0]   cmd_address,
  input  logic [TL_SIZE_WIDTH-1:0]   cmd_size,
  input  logic [TL_STRB_WIDTH-1:0]   cmd_mask,
  input  logic [TL_DATA_WIDTH-1:0]   cmd_data,
  output logic                       a_valid,
  input  logic                       a_ready,
  output logic [2:0]                 a_opcode,
  output logic [2:0]                 a_param,
  output logic [TL_ADDR_WIDTH-1:0]   a_address,
  output logic [TL_SIZE_WIDTH-1:0]   a_size,
  output logic [TL_STRB_WIDTH-1:0]   a_mask,
  output logic [TL_DATA_WIDTH-1:0]   a_data,
  output logic [TL_SOURCE_WIDTH-1:0] a_source,
  input  logic                       d_valid,
  output logic                       d_ready,
  input  logic [2:0]                 d_opcode,
  input  logic [2:0]                 d_param,
  input  logic [TL_SIZE_WIDTH-1:0]   d_size,
  input  logic [TL_SINK_WIDTH-1:0]   d_sink,
  input  logic [TL_SOURCE_WIDTH-1:0] d_source,
  input  logic [TL_DATA_WIDTH-1:0]   d_data,
  input  logic                       d_error,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [2:0]                 rsp_opcode,
  output logic [TL_SOURCE_WIDTH-1:0] rsp_source,
  output logic [TL_DATA_WIDTH-1:0]   rsp_data,
  output logic                       rsp_error,
  output logic [TL_SOURCE_WIDTH:0]   outstanding,
  output logic                       proto_err
);

  localparam int NUM_IDS = 2 ** TL_SOURCE_WIDTH;
  localparam int CMD_W   = 6 + TL_ADDR_WIDTH + TL_SIZE_WIDTH + TL_STRB_WIDTH + TL_DATA_WIDTH;

  // Command queue
  logic                     fifo_full, fifo_empty, fifo_pop;
  logic [CMD_W-1:0]         fifo_head;
  logic [2:0]               head_opcode, head_param;
  logic [TL_ADDR_WIDTH-1:0] head_address;
  logic [TL_SIZE_WIDTH-1:0] head_size;
  logic [TL_STRB_WIDTH-1:0] head_mask;
  logic [TL_DATA_WIDTH-1:0] head_data;
  logic                     head_ok, head_bad;

  // A channel
  a_state_e                   state_reg, state_next;
  logic                       load, a_fire;
  logic [2:0]                 a_opcode_reg, a_param_reg;
  logic [TL_ADDR_WIDTH-1:0]   a_address_reg;
  logic [TL_SIZE_WIDTH-1:0]   a_size_reg;
  logic [TL_STRB_WIDTH-1:0]   a_mask_reg;
  logic [TL_DATA_WIDTH-1:0]   a_data_reg;
  logic [TL_SOURCE_WIDTH-1:0] a_source_reg;

  // Source-ID tracking
  logic [NUM_IDS-1:0]         inflight_reg, exp_data_reg, free_mask;
  logic                       free_found;
  logic [TL_SOURCE_WIDTH-1:0] free_id;
  logic [TL_SOURCE_WIDTH:0]   outstanding_reg;

  // D channel and response register
  logic                       d_fire, d_known, d_opc_bad, d_proto;
  logic                       rsp_valid_reg, rsp_error_reg, proto_err_reg;
  logic [2:0]                 rsp_opcode_reg;
  logic [TL_SOURCE_WIDTH-1:0] rsp_source_reg;
  logic [TL_DATA_WIDTH-1:0]   rsp_data_reg;
  logic                       unused_d_fields;

  // D fields that are accepted but not returned to the user
  assign unused_d_fields = ^{d_param, d_size, d_sink};

  // Ready outputs are held low while reset is asserted
  assign cmd_ready = rst_n & ~fifo_full;
  assign d_ready   = rst_n & (~rsp_valid_reg | rsp_ready);

  tl_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid & cmd_ready),
    .push_data ({cmd_opcode, cmd_param, cmd_address, cmd_size, cmd_mask, cmd_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_opcode, head_param, head_address, head_size, head_mask, head_data} = fifo_head;
  assign head_ok  = ~fifo_empty & is_ul_legal(head_opcode);
  assign head_bad = ~fifo_empty & ~is_ul_legal(head_opcode);
  assign fifo_pop = load | head_bad;
  assign a_fire   = (state_reg == A_SEND) & a_ready;

  // An ID is free if below the in-flight limit, not in flight, and not the beat on A
  for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_free
    if (gi < MAX_OUTSTANDING) begin : g_used
      localparam logic [TL_SOURCE_WIDTH-1:0] ID = TL_SOURCE_WIDTH'(gi);
      assign free_mask[gi] = ~inflight_reg[gi] & ~((state_reg == A_SEND) && (a_source_reg == ID));
    end else begin : g_unused
      assign free_mask[gi] = 1'b0;
    end
  end

  // Priority encoder: lowest free ID wins
  always_comb begin
    free_found = 1'b0;
    free_id    = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        free_found = 1'b1;
        free_id    = i[TL_SOURCE_WIDTH-1:0];
      end
    end
  end

  // A FSM next state: load a new head from idle or back-to-back on a fire
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      A_IDLE: begin
        if (head_ok && free_found) begin
          load       = 1'b1;
          state_next = A_SEND;
        end
      end
      A_SEND: begin
        if (a_ready) begin
          if (head_ok && free_found) load = 1'b1;
          else                       state_next = A_IDLE;
        end
      end
      default: state_next = A_IDLE;
    endcase
  end

  // A FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= A_IDLE;
    else        state_reg <= state_next;
  end

  // A-channel field registers, only changed when a new head is loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_opcode_reg  <= '0;
      a_param_reg   <= '0;
      a_address_reg <= '0;
      a_size_reg    <= '0;
      a_mask_reg    <= '0;
      a_data_reg    <= '0;
      a_source_reg  <= '0;
    end else if (load) begin
      a_opcode_reg  <= head_opcode;
      a_param_reg   <= head_param;
      a_address_reg <= head_address;
      a_size_reg    <= head_size;
      a_mask_reg    <= head_mask;
      a_data_reg    <= head_data;
      a_source_reg  <= free_id;
    end
  end

  assign a_valid   = (state_reg == A_SEND);
  assign a_opcode  = a_opcode_reg;
  assign a_param   = a_param_reg;
  assign a_address = a_address_reg;
  assign a_size    = a_size_reg;
  assign a_mask    = a_mask_reg;
  assign a_data    = a_data_reg;
  assign a_source  = a_source_reg;

  assign d_fire    = d_valid & d_ready;
  assign d_known   = inflight_reg[d_source];
  assign d_opc_bad = exp_data_reg[d_source] ? (d_opcode != D_ACCESS_ACK_DATA)
                                            : (d_opcode != D_ACCESS_ACK);
  assign d_proto   = ~d_known | d_opc_bad;

  // In-flight bitmap and expected-response kind per source ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg <= '0;
      exp_data_reg <= '0;
    end else begin
      if (d_fire) inflight_reg[d_source] <= 1'b0;
      if (a_fire) begin
        inflight_reg[a_source_reg] <= 1'b1;
        exp_data_reg[a_source_reg] <= (a_opcode_reg == A_GET);
      end
    end
  end

  // Outstanding counter; stray D beats do not decrement it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_reg <= '0;
    end else begin
      case ({a_fire, d_fire & d_known})
        2'b10:   outstanding_reg <= outstanding_reg + {{TL_SOURCE_WIDTH{1'b0}}, 1'b1};
        2'b01:   outstanding_reg <= outstanding_reg - {{TL_SOURCE_WIDTH{1'b0}}, 1'b1};
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

  // One-entry response register plus sticky protocol-error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg  <= 1'b0;
      rsp_opcode_reg <= '0;
      rsp_source_reg <= '0;
      rsp_data_reg   <= '0;
      rsp_error_reg  <= 1'b0;
      proto_err_reg  <= 1'b0;
    end else begin
      if (d_fire) begin
        rsp_valid_reg  <= 1'b1;
        rsp_opcode_reg <= d_opcode;
        rsp_source_reg <= d_source;
        rsp_data_reg   <= d_data;
        rsp_error_reg  <= d_error | d_proto;
      end else if (rsp_ready) begin
        rsp_valid_reg  <= 1'b0;
      end
      if ((d_fire && d_proto) || head_bad) proto_err_reg <= 1'b1;
    end
  end

  assign rsp_valid   = rsp_valid_reg;
  assign rsp_opcode  = rsp_opcode_reg;
  assign rsp_source  = rsp_source_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_error   = rsp_error_reg;
  assign outstanding = outstanding_reg;
  assign proto_err   = proto_err_reg;

endmodule

// File: tb/tb_tilelink_ul_master_mo.sv
// Directed and randomized bench for tilelink_ul_master_mo with a
// transaction-level reference model (command queue, ID set, response queue).
module tb_tilelink_ul_master_mo;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  param;
    logic [63:0] addr;
    logic [7:0]  size;
    logic [7:0]  mask;
    logic [63:0] data;
  } cmd_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  src;
    logic [63:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_opcode, cmd_param;
  logic [63:0] cmd_address, cmd_data;
  logic [7:0]  cmd_size, cmd_mask;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param, a_source;
  logic [63:0] a_address, a_data;
  logic [7:0]  a_size, a_mask;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode, d_param, d_sink, d_source;
  logic [7:0]  d_size;
  logic [63:0] d_data;
  logic        d_error;
  logic        rsp_valid, rsp_ready;
  logic [2:0]  rsp_opcode, rsp_source;
  logic [63:0] rsp_data;
  logic        rsp_error;
  logic [3:0]  outstanding;
  logic        proto_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  cmd_t cmdq[$];
  rsp_t rspq[$];
  bit   m_inflight[8];
  bit   m_exp[8];
  int   m_cnt = 0;
  bit   a_hold = 0;
  cmd_t cur;

  always #5 clk = ~clk;

  tilelink_ul_master_mo dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode), .cmd_param(cmd_param),
    .cmd_address(cmd_address), .cmd_size(cmd_size), .cmd_mask(cmd_mask), .cmd_data(cmd_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_address(a_address), .a_size(a_size), .a_mask(a_mask), .a_data(a_data), .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
    .d_sink(d_sink), .d_source(d_source), .d_data(d_data), .d_error(d_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_opcode(rsp_opcode), .rsp_source(rsp_source),
    .rsp_data(rsp_data), .rsp_error(rsp_error), .outstanding(outstanding), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] data);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_param = 3'd0; cmd_address = addr;
    cmd_size = 8'd3; cmd_mask = 8'hFF; cmd_data = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic d_beat(input logic [2:0] src, input logic [2:0] op, input logic [63:0] data);
    d_valid = 1'b1; d_source = src; d_opcode = op; d_data = data; d_error = 1'b0;
    tick();
    d_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One cycle of random traffic against the transaction-level model
  task automatic rand_cycle(input bit gen);
    cmd_t c;
    rsp_t e;
    int   ids[$];
    int   pick;
    int   r;
    if (gen && $urandom_range(0, 1) == 1) begin
      r = $urandom_range(0, 2);
      c.op    = (r == 0) ? 3'd0 : (r == 1) ? 3'd1 : 3'd4;
      c.param = 3'($urandom_range(0, 7));
      c.addr  = {$urandom, $urandom};
      c.size  = 8'($urandom_range(0, 255));
      c.mask  = 8'($urandom_range(0, 255));
      c.data  = {$urandom, $urandom};
      cmd_valid = 1'b1; cmd_opcode = c.op; cmd_param = c.param; cmd_address = c.addr;
      cmd_size = c.size; cmd_mask = c.mask; cmd_data = c.data;
    end else begin
      cmd_valid = 1'b0;
    end
    a_ready   = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
    rsp_ready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
    for (int i = 0; i < 4; i++) if (m_inflight[i]) ids.push_back(i);
    if (ids.size() > 0 && (!gen || $urandom_range(0, 2) == 0)) begin
      pick     = ids[$urandom_range(0, ids.size() - 1)];
      d_valid  = 1'b1;
      d_source = 3'(pick);
      d_opcode = m_exp[pick] ? 3'd1 : 3'd0;
      d_data   = {$urandom, $urandom};
      d_error  = ($urandom_range(0, 7) == 0);
    end else begin
      d_valid = 1'b0;
    end
    #1;
    chk("rnd_outstanding", outstanding, m_cnt);
    if (a_valid) begin
      if (!a_hold) begin
        if (cmdq.size() == 0) chk("rnd_a_unexpected", 1, 0);
        else begin
          cur = cmdq.pop_front();
          chk("rnd_a_src_free", (m_inflight[a_source] || a_source >= 4), 0);
        end
      end
      chk("rnd_a_opcode", a_opcode, cur.op);
      chk("rnd_a_param", a_param, cur.param);
      chk("rnd_a_address", a_address, cur.addr);
      chk("rnd_a_size", a_size, cur.size);
      chk("rnd_a_mask", a_mask, cur.mask);
      chk("rnd_a_data", a_data, cur.data);
      if (a_ready) begin
        m_inflight[a_source] = 1'b1;
        m_exp[a_source] = (cur.op == 3'd4);
        m_cnt++;
        a_hold = 1'b0;
      end else begin
        a_hold = 1'b1;
      end
    end
    if (cmd_valid && cmd_ready) cmdq.push_back(c);
    if (rsp_valid && rsp_ready) begin
      if (rspq.size() == 0) chk("rnd_rsp_unexpected", 1, 0);
      else begin
        e = rspq.pop_front();
        chk("rnd_rsp_opcode", rsp_opcode, e.op);
        chk("rnd_rsp_source", rsp_source, e.src);
        chk("rnd_rsp_data", rsp_data, e.data);
        chk("rnd_rsp_error", rsp_error, e.err);
      end
    end
    if (d_valid && d_ready) begin
      e.op = d_opcode; e.src = d_source; e.data = d_data; e.err = d_error;
      rspq.push_back(e);
      m_inflight[d_source] = 1'b0;
      m_cnt--;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    cmd_valid = 0; cmd_opcode = 0; cmd_param = 0; cmd_address = 0; cmd_size = 0; cmd_mask = 0; cmd_data = 0;
    a_ready = 0; d_valid = 0; d_opcode = 0; d_param = 0; d_size = 0; d_sink = 0; d_source = 0;
    d_data = 0; d_error = 0; rsp_ready = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_proto_err", proto_err, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rel_cmd_ready", cmd_ready, 1);
    a_ready = 1'b1; rsp_ready = 1'b1;

    // Single GET, two-cycle latency, AccessAckData reply
    push_cmd(3'd4, 64'h10, 64'h0);
    chk("get_lat_n1", a_valid, 0);
    tick();
    chk("get_a_valid", a_valid, 1);
    chk("get_a_opcode", a_opcode, 4);
    chk("get_a_source", a_source, 0);
    chk("get_a_address", a_address, 64'h10);
    chk("get_a_size", a_size, 3);
    tick();
    chk("get_a_done", a_valid, 0);
    chk("get_outstanding", outstanding, 1);
    d_valid = 1'b1; d_source = 3'd0; d_opcode = 3'd1; d_data = 64'hDEAD; d_error = 1'b0;
    #1 chk("get_d_ready", d_ready, 1);
    tick();
    d_valid = 1'b0;
    chk("get_rsp_valid", rsp_valid, 1);
    chk("get_rsp_data", rsp_data, 64'hDEAD);
    chk("get_rsp_opcode", rsp_opcode, 1);
    chk("get_rsp_error", rsp_error, 0);
    chk("get_outstanding0", outstanding, 0);
    tick();

    // Four back-to-back PUT_FULL, fifth stalls until source 2 frees
    for (int k = 0; k < 8; k++) begin
      if (k >= 2 && k <= 5) begin
        chk("b2b_a_valid", a_valid, 1);
        chk("b2b_a_source", a_source, k - 2);
        chk("b2b_a_address", a_address, 64'(k - 2));
      end else begin
        chk("b2b_a_idle", a_valid, 0);
      end
      if (k < 5) begin
        cmd_valid = 1'b1; cmd_opcode = 3'd0; cmd_param = 3'd0; cmd_address = 64'(k);
        cmd_size = 8'd3; cmd_mask = 8'hFF; cmd_data = 64'(k);
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
    end
    repeat (3) begin
      chk("stall_a_valid", a_valid, 0);
      chk("stall_outstanding", outstanding, 4);
      tick();
    end
    d_beat(3'd2, 3'd0, 64'h0);
    chk("free_a_not_yet", a_valid, 0);
    chk("free_rsp_source", rsp_source, 2);
    chk("free_rsp_error", rsp_error, 0);
    chk("free_outstanding", outstanding, 3);
    tick();
    chk("reuse_a_valid", a_valid, 1);
    chk("reuse_a_source", a_source, 2);
    chk("reuse_a_address", a_address, 64'd4);
    tick();
    d_beat(3'd0, 3'd0, 64'h0);
    d_beat(3'd1, 3'd0, 64'h0);
    d_beat(3'd3, 3'd0, 64'h0);
    d_beat(3'd2, 3'd0, 64'h0);
    tick();
    chk("b2b_drain_outstanding", outstanding, 0);
    chk("b2b_proto_err", proto_err, 0);

    // A held stable under a_ready=0
    a_ready = 1'b0;
    push_cmd(3'd4, 64'h40, 64'h0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("hold_a_valid", a_valid, 1);
      chk("hold_a_opcode", a_opcode, 4);
      chk("hold_a_address", a_address, 64'h40);
      chk("hold_a_source", a_source, 0);
      tick();
    end
    a_ready = 1'b1;
    tick();
    chk("hold_fired", a_valid, 0);
    chk("hold_one_inflight", outstanding, 1);
    d_beat(3'd0, 3'd1, 64'h1234);
    chk("hold_rsp_error", rsp_error, 0);
    chk("hold_outstanding0", outstanding, 0);

    // Response backpressure with two D beats pending
    push_cmd(3'd4, 64'h100, 64'h0);
    push_cmd(3'd4, 64'h108, 64'h0);
    repeat (5) tick();
    chk("bp_outstanding2", outstanding, 2);
    rsp_ready = 1'b0;
    d_valid = 1'b1; d_source = 3'd0; d_opcode = 3'd1; d_data = 64'hAAAA; d_error = 1'b0;
    #1 chk("bp_d_ready_first", d_ready, 1);
    tick();
    d_source = 3'd1; d_data = 64'hBBBB;
    #1 chk("bp_d_ready_blocked", d_ready, 0);
    repeat (2) begin
      tick();
      chk("bp_d_ready_held", d_ready, 0);
      chk("bp_rsp_first", rsp_data, 64'hAAAA);
      chk("bp_rsp_first_src", rsp_source, 0);
      chk("bp_outstanding1", outstanding, 1);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_d_ready_open", d_ready, 1);
    tick();
    d_valid = 1'b0;
    chk("bp_rsp_second", rsp_data, 64'hBBBB);
    chk("bp_rsp_second_src", rsp_source, 1);
    chk("bp_outstanding0", outstanding, 0);
    tick();
    chk("bp_rsp_idle", rsp_valid, 0);

    // Randomized traffic then drain
    a_hold = 1'b0;
    for (int i = 0; i < 8; i++) begin m_inflight[i] = 1'b0; m_exp[i] = 1'b0; end
    m_cnt = 0;
    repeat (400) rand_cycle(1'b1);
    repeat (80) rand_cycle(1'b0);
    chk("rnd_drain_outstanding", outstanding, 0);
    chk("rnd_drain_cmdq", cmdq.size(), 0);
    chk("rnd_drain_rspq", rspq.size(), 0);
    chk("rnd_drain_a_valid", a_valid, 0);
    chk("rnd_proto_err", proto_err, 0);
    a_ready = 1'b1; rsp_ready = 1'b1; cmd_valid = 1'b0; d_valid = 1'b0;
    tick();

    // Stray D source while another request is in flight
    push_cmd(3'd4, 64'h80, 64'h0);
    repeat (3) tick();
    chk("stray_pre_outstanding", outstanding, 1);
    d_beat(3'd5, 3'd1, 64'h55);
    chk("stray_rsp_error", rsp_error, 1);
    chk("stray_rsp_source", rsp_source, 5);
    chk("stray_proto_err", proto_err, 1);
    chk("stray_outstanding", outstanding, 1);
    d_beat(3'd0, 3'd1, 64'h66);
    chk("stray_good_rsp_error", rsp_error, 0);
    chk("stray_good_outstanding", outstanding, 0);
    reset_pulse();
    chk("pulse_proto_clear", proto_err, 0);

    // GET answered with AccessAck
    push_cmd(3'd4, 64'h90, 64'h0);
    repeat (3) tick();
    d_beat(3'd0, 3'd0, 64'h77);
    chk("badack_rsp_error", rsp_error, 1);
    chk("badack_proto_err", proto_err, 1);
    chk("badack_outstanding", outstanding, 0);
    reset_pulse();

    // Illegal command opcode is discarded without an A beat
    push_cmd(3'd6, 64'hB0, 64'h0);
    repeat (5) begin
      chk("illegal_no_a", a_valid, 0);
      tick();
    end
    chk("illegal_proto_err", proto_err, 1);
    push_cmd(3'd4, 64'hC0, 64'h0);
    tick();
    chk("after_illegal_a_valid", a_valid, 1);
    chk("after_illegal_address", a_address, 64'hC0);
    tick();
    d_beat(3'd0, 3'd1, 64'h0);

    // Reset with two in flight and three queued
    push_cmd(3'd4, 64'hD0, 64'h0);
    push_cmd(3'd0, 64'hD8, 64'h0);
    repeat (4) tick();
    chk("mid_outstanding2", outstanding, 2);
    a_ready = 1'b0;
    push_cmd(3'd0, 64'hE0, 64'h0);
    push_cmd(3'd0, 64'hE8, 64'h0);
    push_cmd(3'd0, 64'hF0, 64'h0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_a_valid", a_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_d_ready", d_ready, 0);
    chk("mid_rst_outstanding", outstanding, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_proto_err", proto_err, 0);
    chk("mid_rst_a_source", a_source, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rel_cmd_ready", cmd_ready, 1);
    a_ready = 1'b1;
    repeat (4) begin
      chk("mid_no_replay", a_valid, 0);
      tick();
    end
    chk("mid_final_outstanding", outstanding, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
